lowrisc_hwrng_health: RTL and testbench

Downstream consumer of the ring-oscillator entropy FIFO. Pops 32-bit words from the FIFO and runs continuous health tests on every word: a repetition-count test (RCT) and an adaptive-proportion test (APT). Words that pass are presented to the SoC on a valid/ready stream. Sits between the hwrng FIFO read port and the peripheral register/bus logic that software reads.

---
 rtl/lowrisc_hwrng_health.sv | 164 ++++++++++++++++
 tb/tb_lowrisc_hwrng_health.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lowrisc_hwrng_health.sv
// Entropy health monitor: pops words from the ring-oscillator FIFO, runs RCT/APT, streams passing words.
// Latency: READ_LAT+2 cycles from the fifo_rd_o pulse to rnd_valid_o; one word per READ_LAT+4 cycles.
// Backpressure: a word waits in OUT (data stable) until rnd_ready_i; no further reads are issued meanwhile.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   fifo_empty_i/data_i/rderr_i  FIFO read-side status, data (DO) and read-error flag
//   fifo_rd_o                    one-cycle read pulse to the FIFO
//   rnd_valid_o/data_o/ready_i   output random-word stream
//   alarm_clr_i                  clears alarms/underflow and restarts the startup discard
//   alarm_rct_o, alarm_apt_o     sticky health-test failures
//   underflow_o                  sticky FIFO read-error flag
//   startup_done_o               startup discard complete
module lowrisc_hwrng_health #(
  parameter int READ_LAT      = 3,
  parameter int STARTUP_WORDS = 4,
  parameter int RCT_CUTOFF    = 4,
  parameter int APT_WINDOW    = 64,
  parameter int APT_CUTOFF    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fifo_empty_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_rderr_i,
  output logic        fifo_rd_o,
  output logic        rnd_valid_o,
  output logic [31:0] rnd_data_o,
  input  logic        rnd_ready_i,
  input  logic        alarm_clr_i,
  output logic        alarm_rct_o,
  output logic        alarm_apt_o,
  output logic        underflow_o,
  output logic        startup_done_o
);

  localparam int LAT_W = $clog2(READ_LAT) + 1;
  localparam int DSC_W = $clog2(STARTUP_WORDS) + 1;
  localparam int RCT_W = $clog2(RCT_CUTOFF) + 1;
  localparam int WIN_W = $clog2(APT_WINDOW) + 1;
  localparam int APT_W = $clog2(APT_CUTOFF) + 1;

  localparam logic [LAT_W-1:0] WAIT_LAST = LAT_W'((READ_LAT >= 2) ? READ_LAT - 2 : 0);
  localparam logic [DSC_W-1:0] DSC_MAX   = DSC_W'(STARTUP_WORDS);
  localparam logic [RCT_W-1:0] RCT_MAX   = RCT_W'(RCT_CUTOFF);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(APT_WINDOW - 1);
  localparam logic [APT_W-1:0] APT_MAX   = APT_W'(APT_CUTOFF);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPTURE, CHECK, OUT} state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   wait_q;
  logic [31:0]        word_q, prev_q;
  logic [RCT_W-1:0]   rct_q;
  logic [7:0]         ref_q;
  logic [WIN_W-1:0]   win_q;
  logic [APT_W-1:0]   apt_q;
  logic [DSC_W-1:0]   dsc_q;
  logic               rd_q, alarm_rct_q, alarm_apt_q, underflow_q;

  // A clear coinciding with CHECK evaluates the word against the cleared state.
  logic [RCT_W-1:0]   rct_eff, rct_nxt;
  logic [WIN_W-1:0]   win_eff, win_nxt;
  logic [APT_W-1:0]   apt_eff, apt_nxt;
  logic [DSC_W-1:0]   dsc_eff;
  logic [7:0]         ref_nxt;
  logic               rct_trip, apt_trip, trip;

  always_comb begin
    rct_eff = alarm_clr_i ? '0 : rct_q;
    win_eff = alarm_clr_i ? '0 : win_q;
    apt_eff = alarm_clr_i ? '0 : apt_q;
    dsc_eff = alarm_clr_i ? '0 : dsc_q;

    // rct count of zero means "no previous word", so the first word always restarts at 1.
    rct_nxt = RCT_W'(1);
    if ((rct_eff != '0) && (word_q == prev_q)) begin
      rct_nxt = (rct_eff >= RCT_MAX) ? rct_eff : rct_eff + 1'b1;
    end

    ref_nxt = ref_q;
    apt_nxt = apt_eff;
    if (win_eff == '0) begin
      ref_nxt = word_q[7:0];
      apt_nxt = APT_W'(1);
    end else if ((word_q[7:0] == ref_q) && (apt_eff < APT_MAX)) begin
      apt_nxt = apt_eff + 1'b1;
    end
    win_nxt = (win_eff == WIN_LAST) ? '0 : win_eff + 1'b1;

    rct_trip = (rct_nxt >= RCT_MAX);
    apt_trip = (apt_nxt >= APT_MAX);
    trip     = rct_trip || apt_trip;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty_i && !alarm_rct_q && !alarm_apt_q) state_d = REQ;
      REQ:     state_d = (READ_LAT == 1) ? CAPTURE : WAIT;
      WAIT:    if (wait_q == WAIT_LAST) state_d = CAPTURE;
      CAPTURE: state_d = CHECK;
      CHECK:   state_d = (trip || (dsc_eff < DSC_MAX)) ? IDLE : OUT;
      OUT:     if (rnd_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      word_q      <= '0;
      prev_q      <= '0;
      rct_q       <= '0;
      ref_q       <= '0;
      win_q       <= '0;
      apt_q       <= '0;
      dsc_q       <= '0;
      rd_q        <= 1'b0;
      alarm_rct_q <= 1'b0;
      alarm_apt_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= (state_d == REQ);
      wait_q  <= (state_q == WAIT) ? wait_q + 1'b1 : '0;
      if (state_q == CAPTURE) word_q <= fifo_data_i;

      if (alarm_clr_i) begin
        rct_q       <= '0;
        prev_q      <= '0;
        win_q       <= '0;
        apt_q       <= '0;
        dsc_q       <= '0;
        alarm_rct_q <= 1'b0;
        alarm_apt_q <= 1'b0;
        underflow_q <= 1'b0;
      end

      // Placed after the clear so that a simultaneous set wins.
      if (state_q == CHECK) begin
        rct_q  <= rct_nxt;
        prev_q <= word_q;
        win_q  <= win_nxt;
        apt_q  <= apt_nxt;
        ref_q  <= ref_nxt;
        if (rct_trip) alarm_rct_q <= 1'b1;
        if (apt_trip) alarm_apt_q <= 1'b1;
        if (!trip && (dsc_eff < DSC_MAX)) dsc_q <= dsc_eff + 1'b1;
      end
      if (fifo_rderr_i) underflow_q <= 1'b1;
    end
  end

  assign fifo_rd_o      = rd_q;
  assign rnd_valid_o    = (state_q == OUT);
  assign rnd_data_o     = word_q;
  assign alarm_rct_o    = alarm_rct_q;
  assign alarm_apt_o    = alarm_apt_q;
  assign underflow_o    = underflow_q;
  assign startup_done_o = (dsc_q == DSC_MAX);

endmodule

// File: tb/tb_lowrisc_hwrng_health.sv
module tb_lowrisc_hwrng_health;
  localparam int READ_LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i, fifo_empty_i, fifo_rderr_i, fifo_rd_o;
  logic [31:0] fifo_data_i, rnd_data_o;
  logic        rnd_valid_o, rnd_ready_i, alarm_clr_i;
  logic        alarm_rct_o, alarm_apt_o, underflow_o, startup_done_o;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int ncnt = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] pipe_dat[$];
  int          pipe_due[$];
  logic [31:0] out_q[$];

  lowrisc_hwrng_health #(
    .READ_LAT(READ_LAT), .STARTUP_WORDS(4), .RCT_CUTOFF(4), .APT_WINDOW(64), .APT_CUTOFF(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rderr_i(fifo_rderr_i), .fifo_rd_o(fifo_rd_o), .rnd_valid_o(rnd_valid_o),
    .rnd_data_o(rnd_data_o), .rnd_ready_i(rnd_ready_i), .alarm_clr_i(alarm_clr_i),
    .alarm_rct_o(alarm_rct_o), .alarm_apt_o(alarm_apt_o), .underflow_o(underflow_o),
    .startup_done_o(startup_done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // FIFO read side: a pulse seen in cycle c puts the popped word on DO only around the edge ending c+READ_LAT.
  initial begin
    int d;
    fifo_data_i  = 32'h0BAD_F00D;
    fifo_empty_i = 1'b1;
    forever begin
      @(negedge clk_i);
      ncnt++;
      fifo_data_i = 32'h0BAD_F00D;
      if (pipe_due.size() > 0 && pipe_due[0] == ncnt) begin
        fifo_data_i = pipe_dat.pop_front();
        d = pipe_due.pop_front();
      end
      if (fifo_rd_o === 1'b1) begin
        rd_count++;
        if (fifo_q.size() > 0) pipe_dat.push_back(fifo_q.pop_front());
        else pipe_dat.push_back(32'h0BAD_F00D);
        pipe_due.push_back(ncnt + READ_LAT);
      end
      fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  // Output stream monitor.
  initial forever begin
    @(negedge clk_i);
    if (rnd_valid_o === 1'b1 && rnd_ready_i === 1'b1 && rst_i === 1'b0) out_q.push_back(rnd_data_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_pt();  @(posedge clk_i); #1; endtask
  task automatic sample_pt(); @(negedge clk_i); #1; endtask
  task automatic idle(input int n); repeat (n) sample_pt(); endtask

  task automatic wait_outs(input string tag, input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin sample_pt(); k++; end
    chk(tag, 32'(out_q.size()), 32'(n));
  endtask

  task automatic pop_out(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    obs = ~exp;
    if (out_q.size() > 0) obs = out_q.pop_front();
    chk(tag, obs, exp);
  endtask

  task automatic pulse_clr();
    drive_pt(); alarm_clr_i = 1'b1;
    drive_pt(); alarm_clr_i = 1'b0;
  endtask

  // mode 0: 0x5A low byte on every third word; mode 1: 7 matches in window 0, two at the start of window 1.
  function automatic logic [31:0] apt_word(input int i, input bit mode);
    bit m;
    m = mode ? (((i % 3) == 0 && i <= 18) || i >= 64) : ((i % 3) == 0);
    return {8'hA5, 16'(i), m ? 8'h5A : 8'(i + 128)};
  endfunction

  int t_rd;
  int vt[3];
  int nv;
  int r0;
  int bad;
  int k;
  logic [31:0] last;

  initial begin
    rst_i = 1'b1; rnd_ready_i = 1'b1; alarm_clr_i = 1'b0; fifo_rderr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    sample_pt();
    chk("rst_fifo_rd", 32'(fifo_rd_o), 32'd0);
    chk("rst_valid", 32'(rnd_valid_o), 32'd0);
    chk("rst_data", rnd_data_o, 32'd0);
    chk("rst_alarm_rct", 32'(alarm_rct_o), 32'd0);
    chk("rst_alarm_apt", 32'(alarm_apt_o), 32'd0);
    chk("rst_underflow", 32'(underflow_o), 32'd0);
    chk("rst_startup_done", 32'(startup_done_o), 32'd0);

    // Startup discard: words 0..3 dropped, 4 and 5 delivered.
    drive_pt();
    for (int i = 0; i < 6; i++) fifo_q.push_back(32'h1111_0001 + 32'(i) * 32'h0101_0001);
    k = 0;
    while (startup_done_o !== 1'b1 && k < 100) begin sample_pt(); k++; end
    chk("startup_done_rise", 32'(startup_done_o), 32'd1);
    chk("startup_done_after_rd4", 32'(rd_count), 32'd4);
    wait_outs("startup_out_count", 2, 100);
    pop_out("startup_word5", 32'h1111_0001 + 32'd4 * 32'h0101_0001);
    pop_out("startup_word6", 32'h1111_0001 + 32'd5 * 32'h0101_0001);
    idle(10);
    chk("startup_rd_pulses", 32'(rd_count), 32'd6);

    // Latency and throughput with ready held high.
    drive_pt();
    for (int i = 0; i < 3; i++) fifo_q.push_back(32'h2222_0011 + 32'(i));
    t_rd = -1000; nv = 0;
    for (int i = 0; i < 3; i++) vt[i] = -2000;
    for (int c = 0; c < 60; c++) begin
      sample_pt();
      if (fifo_rd_o === 1'b1 && t_rd < 0) t_rd = c;
      if (rnd_valid_o === 1'b1 && nv < 3) begin vt[nv] = c; nv++; end
    end
    chk("lat_first_valid", 32'(vt[0] - t_rd), 32'(READ_LAT + 2));
    chk("lat_spacing_1", 32'(vt[1] - vt[0]), 32'(READ_LAT + 4));
    chk("lat_spacing_2", 32'(vt[2] - vt[1]), 32'(READ_LAT + 4));
    pop_out("lat_word0", 32'h2222_0011);
    pop_out("lat_word1", 32'h2222_0012);
    pop_out("lat_word2", 32'h2222_0013);

    // RCT: fourth identical word trips and is not delivered.
    r0 = rd_count;
    drive_pt();
    repeat (4) fifo_q.push_back(32'hDEAD_BEEF);
    wait_outs("rct_out_count", 3, 100);
    for (int i = 0; i < 3; i++) pop_out("rct_copy", 32'hDEAD_BEEF);
    k = 0;
    while (alarm_rct_o !== 1'b1 && k < 50) begin sample_pt(); k++; end
    chk("rct_alarm_set", 32'(alarm_rct_o), 32'd1);
    chk("rct_no_apt", 32'(alarm_apt_o), 32'd0);
    chk("rct_reads", 32'(rd_count - r0), 32'd4);
    r0 = rd_count;
    drive_pt();
    fifo_q.push_back(32'h3333_0021);
    fifo_q.push_back(32'h3333_0022);
    idle(30);
    chk("rct_halt_reads", 32'(rd_count), 32'(r0));
    chk("rct_fourth_dropped", 32'(out_q.size()), 32'd0);
    pulse_clr();
    sample_pt();
    chk("rct_alarm_cleared", 32'(alarm_rct_o), 32'd0);
    chk("rct_startup_restart", 32'(startup_done_o), 32'd0);
    drive_pt();
    for (int i = 0; i < 3; i++) fifo_q.push_back(32'h3333_0023 + 32'(i));
    wait_outs("rct_resume_count", 1, 150);
    pop_out("rct_resume_word", 32'h3333_0025);
    chk("rct_resume_reads", 32'(rd_count - r0), 32'd5);

    // APT trip at the 8th match (word 21).
    pulse_clr();
    r0 = rd_count;
    drive_pt();
    for (int i = 0; i < 64; i++) fifo_q.push_back(apt_word(i, 1'b0));
    k = 0;
    while (alarm_apt_o !== 1'b1 && k < 400) begin sample_pt(); k++; end
    chk("apt_alarm_set", 32'(alarm_apt_o), 32'd1);
    idle(20);
    chk("apt_reads", 32'(rd_count - r0), 32'd22);
    chk("apt_no_rct", 32'(alarm_rct_o), 32'd0);
    chk("apt_out_count", 32'(out_q.size()), 32'd17);
    for (int i = 4; i < 21; i++) pop_out("apt_word", apt_word(i, 1'b0));
    fifo_q.delete();
    pulse_clr();
    sample_pt();
    chk("apt_alarm_cleared", 32'(alarm_apt_o), 32'd0);

    // APT: 7 matches then window wrap does not trip.
    drive_pt();
    for (int i = 0; i < 66; i++) fifo_q.push_back(apt_word(i, 1'b1));
    wait_outs("apt_wrap_out_count", 62, 800);
    chk("apt_wrap_no_alarm", 32'(alarm_apt_o), 32'd0);
    last = 32'h0;
    while (out_q.size() > 0) last = out_q.pop_front();
    chk("apt_wrap_last_word", last, apt_word(65, 1'b1));

    // Backpressure: output held stable, no reads while stalled.
    drive_pt();
    rnd_ready_i = 1'b0;
    fifo_q.push_back(32'h4444_00C1);
    k = 0;
    while (rnd_valid_o !== 1'b1 && k < 50) begin sample_pt(); k++; end
    chk("bp_valid", 32'(rnd_valid_o), 32'd1);
    drive_pt();
    fifo_q.push_back(32'h4444_00C2);
    r0 = rd_count;
    bad = 0;
    repeat (20) begin
      sample_pt();
      if (rnd_valid_o !== 1'b1 || rnd_data_o !== 32'h4444_00C1 || fifo_rd_o !== 1'b0) bad++;
    end
    chk("bp_unstable_cycles", 32'(bad), 32'd0);
    chk("bp_no_reads", 32'(rd_count), 32'(r0));
    drive_pt();
    rnd_ready_i = 1'b1;
    wait_outs("bp_out_count", 2, 100);
    pop_out("bp_word0", 32'h4444_00C1);
    pop_out("bp_word1", 32'h4444_00C2);

    // Empty FIFO: no reads. Underflow sticky until clear; set beats clear.
    idle(5);
    r0 = rd_count;
    idle(30);
    chk("empty_no_reads", 32'(rd_count), 32'(r0));
    drive_pt(); fifo_rderr_i = 1'b1;
    drive_pt(); fifo_rderr_i = 1'b0;
    sample_pt();
    chk("uf_set", 32'(underflow_o), 32'd1);
    idle(10);
    chk("uf_sticky", 32'(underflow_o), 32'd1);
    pulse_clr();
    sample_pt();
    chk("uf_cleared", 32'(underflow_o), 32'd0);
    drive_pt(); fifo_rderr_i = 1'b1; alarm_clr_i = 1'b1;
    drive_pt(); fifo_rderr_i = 1'b0; alarm_clr_i = 1'b0;
    sample_pt();
    chk("uf_set_beats_clr", 32'(underflow_o), 32'd1);

    // Reset during WAIT: in-flight word lost, outputs back to reset values.
    drive_pt();
    fifo_q.push_back(32'h5555_00D1);
    k = 0;
    while (fifo_rd_o !== 1'b1 && k < 30) begin sample_pt(); k++; end
    chk("rstw_read_issued", 32'(fifo_rd_o), 32'd1);
    r0 = rd_count;
    drive_pt(); rst_i = 1'b1;
    drive_pt(); rst_i = 1'b0;
    sample_pt();
    chk("rstw_fifo_rd", 32'(fifo_rd_o), 32'd0);
    chk("rstw_valid", 32'(rnd_valid_o), 32'd0);
    chk("rstw_alarm_rct", 32'(alarm_rct_o), 32'd0);
    chk("rstw_alarm_apt", 32'(alarm_apt_o), 32'd0);
    chk("rstw_underflow", 32'(underflow_o), 32'd0);
    idle(30);
    chk("rstw_word_lost", 32'(out_q.size()), 32'd0);
    chk("rstw_no_reread", 32'(rd_count), 32'(r0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
